regbus_arbiter: RTL and testbench
=================================

# regbus_arbiter

Shares the single strobe-based register bus that feeds the address decoder between several requesters, e.g. the C64 expansion-port I/O logic and the host debug port. It accepts one valid/ack request per master, grants them round-robin, and issues exactly one single-cycle read or write strobe per grant. For reads it captures `bus_read_data` after a fixed latency and returns it to the granted master with an ack pulse.

## Interface
Parameters:
- `MASTERS`, 2: number of requesters (2..8).
- `A_BITS`, 16: bus address width; matches the decoder's address width.
- `D`, 8: data width.
- `RD_LAT`, 1: cycles from the read strobe to the `bus_read_data` sample (0..3).

Ports:
- `clk`  in  1: sole clock; every flop is on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  MASTERS: per-master request; held until that master's ack.
- `req_we`  in  MASTERS: 1 = write, 0 = read.
- `req_addr`  in  MASTERS*A_BITS: packed addresses; master i occupies bits [i*A_BITS +: A_BITS].
- `req_wdata`  in  MASTERS*D: packed write data.
- `req_ack`  out  MASTERS: one-cycle completion pulse, at most one bit set.
- `req_rdata`  out  MASTERS*D: per-master read data, held until that master's next read ack.
- `bus_a`  out  A_BITS: bus address to the decoder.
- `bus_read_strobe`  out  1: one-cycle read strobe.
- `bus_write_strobe`  out  1: one-cycle write strobe.
- `bus_wdata`  out  D: write data, valid during the write strobe.
- `bus_read_data`  in  D: read return from the decoder (0xff when nothing is selected).

## Operation
- FSM states:
  - IDLE: if any `req_valid`, latch the winner's index, we, addr and wdata, then go to STROBE. Otherwise stay in IDLE.
  - STROBE: drive the strobe selected by we for exactly one cycle. Next state is ACK for a write, or for a read with RD_LAT=0. Otherwise next state is WAIT.
  - WAIT: count RD_LAT cycles, then go to ACK.
  - ACK: pulse `req_ack[grant]`, then return to IDLE.
- Read capture:
  - `bus_read_data` is sampled in the cycle RD_LAT cycles after the strobe cycle (RD_LAT=0 samples in the strobe cycle itself).
  - The sample is written into `req_rdata[grant]`, valid in the ACK cycle.
- Arbitration is round-robin:
  - The priority pointer resets to 0.
  - After granting master g, the pointer becomes (g+1) mod MASTERS.
  - On simultaneous requests, the first requester at or after the pointer wins.
- Request fields are latched in IDLE; changes to the inputs after the grant do not affect the transaction in flight.
- `bus_a` and `bus_wdata` hold the latched values from STROBE until the next grant. The bus is never left with both strobes high.
- A write ack leaves `req_rdata` unchanged.
- Reset values:
  - FSM in IDLE, pointer 0.
  - `req_ack`, both strobes, `bus_a`, `bus_wdata` and every `req_rdata` are all 0.
- Reset mid-transaction: the transaction is dropped with no ack, and the strobes are low from the cycle after the reset edge.

## Timing
- Minimum transaction (write, or read with RD_LAT=0) is 3 cycles from the valid being seen in IDLE to the ack: grant, strobe, ack.
- A read takes 3+RD_LAT cycles.
- Back-to-back transactions:
  - The next grant is evaluated in the cycle after ACK.
  - A master that keeps `req_valid` high after its ack is treated as issuing a new request.
  - Throughput is one transaction per 3+RD_LAT cycles.
- `req_ack` is never high in two consecutive cycles.
- `req_ack` is never high for a master whose `req_valid` was low when it was granted.

## Structure
- Package `regbus_pkg`:
  - the state enum (IDLE, STROBE, WAIT, ACK);
  - `RD_LAT_MAX`=3;
  - the width of the latency counter (2 bits).
- Sub-module `rr_pick`:
  - purely combinational;
  - inputs: request vector and pointer;
  - outputs: one-hot grant and the winner's index.
- Remaining logic lives in `regbus_arbiter`: FSM, field latches, latency counter, per-master rdata registers.

## Test plan
- Single write, master 0, addr 0xDF00, data 0x5A, RD_LAT=1 -> one-cycle `bus_write_strobe` with `bus_a`=0xDF00 and `bus_wdata`=0x5A; `req_ack`=01 two cycles later; `req_rdata` unchanged.
- Read, master 1, addr 0xDF02, decoder returns 0x3C at RD_LAT=2 -> `bus_read_strobe` once, `req_ack`=10 at cycle 5, `req_rdata[1]`=0x3C and held afterwards.
- Both masters request continuously -> grants alternate 0,1,0,1; each ack spaced 3+RD_LAT cycles; no overlapping strobes.
- Read to an unmapped address with the decoder returning 0xff -> ack with `req_rdata`=0xFF; no error or hang.
- Reset asserted in the WAIT cycle -> no ack; strobes 0 and pointer 0 next cycle; the following request to master 1 completes normally.
- RD_LAT=0 read -> data sampled in the strobe cycle; ack at cycle 3.

Source files
------------

// File: rtl/regbus_pkg.sv
// Shared types and limits for the register-bus arbiter.
package regbus_pkg;

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, ACK} state_t;

    localparam int RD_LAT_MAX = 3;
    localparam int LAT_CNT_W  = 2;

    typedef logic [LAT_CNT_W-1:0] lat_cnt_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic found;
        int   j;
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/regbus_arbiter.sv
// Round-robin sharing of a strobe-based register bus between several masters;
// one strobe per grant, read data captured RD_LAT cycles after the strobe.
module regbus_arbiter
    import regbus_pkg::*;
#(
    parameter int MASTERS = 2,
    parameter int A_BITS  = 16,
    parameter int D       = 8,
    parameter int RD_LAT  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [MASTERS-1:0]     req_valid,
    input  logic [MASTERS-1:0]     req_we,
    input  logic [MASTERS*A_BITS-1:0] req_addr,
    input  logic [MASTERS*D-1:0]   req_wdata,
    output logic [MASTERS-1:0]     req_ack,
    output logic [MASTERS*D-1:0]   req_rdata,
    output logic [A_BITS-1:0]      bus_a,
    output logic                   bus_read_strobe,
    output logic                   bus_write_strobe,
    output logic [D-1:0]           bus_wdata,
    input  logic [D-1:0]           bus_read_data
);

    localparam int IW  = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int LAT = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    state_t                    state_q, state_d;
    logic [IW-1:0]             ptr_q, ptr_d;
    logic [IW-1:0]             gidx_q, gidx_d;
    logic [MASTERS-1:0]        gnt_q, gnt_d;
    logic                      we_q, we_d;
    logic [A_BITS-1:0]         bus_a_q, bus_a_d;
    logic [D-1:0]              wdata_q, wdata_d;
    lat_cnt_t                  cnt_q, cnt_d;
    logic                      rd_stb_q, rd_stb_d;
    logic                      wr_stb_q, wr_stb_d;
    logic [MASTERS-1:0]        ack_q, ack_d;
    logic [MASTERS-1:0][D-1:0] rdata_q, rdata_d;

    logic [MASTERS-1:0]        pick_gnt;
    logic [IW-1:0]             pick_idx;

    rr_pick #(.N(MASTERS), .IW(IW)) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        bus_a_d  = bus_a_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rd_stb_d = 1'b0;
        wr_stb_d = 1'b0;
        ack_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    gidx_d   = pick_idx;
                    gnt_d    = pick_gnt;
                    we_d     = req_we[pick_idx];
                    bus_a_d  = req_addr[int'(pick_idx)*A_BITS +: A_BITS];
                    wdata_d  = req_wdata[int'(pick_idx)*D +: D];
                    wr_stb_d = req_we[pick_idx];
                    rd_stb_d = !req_we[pick_idx];
                    if (int'(pick_idx) == MASTERS - 1) ptr_d = '0;
                    else ptr_d = pick_idx + 1'b1;
                    state_d  = STROBE;
                end
            end
            STROBE: begin
                cnt_d = lat_cnt_t'(1);
                if (we_q || LAT == 0) begin
                    if (!we_q) rdata_d[gidx_q] = bus_read_data;
                    ack_d   = gnt_q;
                    state_d = ACK;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // cnt_q counts cycles elapsed since the strobe cycle
                if (cnt_q == lat_cnt_t'(LAT)) begin
                    rdata_d[gidx_q] = bus_read_data;
                    ack_d   = gnt_q;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            gnt_q    <= '0;
            we_q     <= 1'b0;
            bus_a_q  <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            ack_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            bus_a_q  <= bus_a_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rd_stb_q <= rd_stb_d;
            wr_stb_q <= wr_stb_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
        end
    end

    assign req_ack          = ack_q;
    assign req_rdata        = rdata_q;
    assign bus_a            = bus_a_q;
    assign bus_read_strobe  = rd_stb_q;
    assign bus_write_strobe = wr_stb_q;
    assign bus_wdata        = wdata_q;

endmodule

// File: tb/tb_regbus_arbiter.sv
// Bench: three arbiters (RD_LAT 0,1,2) against a transaction-timeline model.
module tb_regbus_arbiter;

    localparam int N = 3;
    localparam int M = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  rv [N] = '{2'b0, 2'b0, 2'b0};
    logic [1:0]  rwe [N];
    logic [31:0] raddr [N];
    logic [15:0] rwd [N];
    logic [1:0]  ack [N];
    logic [15:0] rrd [N];
    logic [15:0] ba [N];
    logic        rs [N];
    logic        ws [N];
    logic [7:0]  bwd [N];
    logic [7:0]  brd [N];
    int          sc [N] = '{0, 0, 0};

    function automatic logic [7:0] dec(input logic [15:0] a);
        if (a == 16'hDF02) return 8'h3C;
        if (a[15:8] == 8'hDF) return a[7:0] ^ 8'hA5;
        return 8'hFF;
    endfunction

    for (genvar k = 0; k < N; k++) begin : g
        regbus_arbiter #(.MASTERS(M), .A_BITS(16), .D(8), .RD_LAT(k)) u_dut (
            .clk              (clk),
            .reset            (reset),
            .req_valid        (rv[k]),
            .req_we           (rwe[k]),
            .req_addr         (raddr[k]),
            .req_wdata        (rwd[k]),
            .req_ack          (ack[k]),
            .req_rdata        (rrd[k]),
            .bus_a            (ba[k]),
            .bus_read_strobe  (rs[k]),
            .bus_write_strobe (ws[k]),
            .bus_wdata        (bwd[k]),
            .bus_read_data    (brd[k])
        );
        // decoder returns real data only in the exact sample cycle
        assign brd[k] = ((k == 0) ? rs[k] : (sc[k] == k)) ? dec(ba[k]) : 8'hEE;
    end

    int          cyc = 0;
    bit          busy [N];
    int          t [N];
    int          gm [N];
    int          ptr [N];
    bit          mwe [N];
    logic [15:0] ma [N];
    logic [7:0]  mrd [N][M];
    logic        e_rs [N];
    logic        e_ws [N];
    logic [1:0]  e_ack [N];
    logic [15:0] e_a [N];
    logic [7:0]  e_wd [N];

    always @(posedge clk) begin
        int d;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (rs[k]) sc[k] <= 1;
            else if (sc[k] > 0 && sc[k] < 7) sc[k] <= sc[k] + 1;
            e_rs[k] = 1'b0;
            e_ws[k] = 1'b0;
            e_ack[k] = 2'b00;
            if (reset) begin
                busy[k] = 1'b0;
                ptr[k] = 0;
                e_a[k] = '0;
                e_wd[k] = '0;
                mrd[k][0] = '0;
                mrd[k][1] = '0;
            end else if (busy[k]) begin
                d = mwe[k] ? 1 : 1 + k;
                t[k]++;
                if (t[k] == d) begin
                    e_ack[k][gm[k]] = 1'b1;
                    if (!mwe[k]) mrd[k][gm[k]] = dec(ma[k]);
                end
                if (t[k] == d + 1) busy[k] = 1'b0;
            end else if (rv[k] != 2'b00) begin
                gm[k] = -1;
                for (int j = 0; j < M; j++)
                    if (gm[k] < 0 && rv[k][(ptr[k] + j) % M]) gm[k] = (ptr[k] + j) % M;
                ptr[k] = (gm[k] + 1) % M;
                busy[k] = 1'b1;
                t[k] = 0;
                mwe[k] = rwe[k][gm[k]];
                ma[k] = raddr[k][gm[k]*16 +: 16];
                e_a[k] = ma[k];
                e_wd[k] = rwd[k][gm[k]*8 +: 8];
                e_ws[k] = mwe[k];
                e_rs[k] = !mwe[k];
            end
        end
    end

    int          checks = 0;
    int          failures = 0;
    int          issued [N][M] = '{default:0};
    int          done [N][M] = '{default:0};
    int          start [N][M] = '{default:0};
    int          lat [N][M] = '{default:0};
    int          last [N] = '{0, 0, 0};
    int          gap [N] = '{0, 0, 0};
    int          nrs [N] = '{0, 0, 0};
    int          nws [N] = '{0, 0, 0};
    logic [3:0]  ord [N] = '{4'h0, 4'h0, 4'h0};
    logic [15:0] sa [N];
    logic [7:0]  sd [N];
    logic [1:0]  prev_ack [N] = '{2'b0, 2'b0, 2'b0};
    int          tmo = 0;
    int          lit_phase = 0;
    int          lit_seen = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", nm, k, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit v;
        for (int k = 0; k < N; k++) begin
            chk("rd_strobe", k, 32'(rs[k]), 32'(e_rs[k]));
            chk("wr_strobe", k, 32'(ws[k]), 32'(e_ws[k]));
            chk("ack", k, 32'(ack[k]), 32'(e_ack[k]));
            chk("bus_a", k, 32'(ba[k]), 32'(e_a[k]));
            chk("bus_wdata", k, 32'(bwd[k]), 32'(e_wd[k]));
            chk("rdata", k, 32'(rrd[k]), {16'h0, mrd[k][1], mrd[k][0]});
            chk("strobe_overlap", k, 32'(rs[k] & ws[k]), 0);
            chk("ack_repeat", k, 32'(prev_ack[k] & ack[k]), 0);
            prev_ack[k] = ack[k];
            if (rs[k]) nrs[k]++;
            if (ws[k]) begin
                nws[k]++;
                sa[k] = ba[k];
                sd[k] = bwd[k];
            end
            for (int m = 0; m < M; m++) begin
                if (ack[k][m] === 1'b1) begin
                    done[k][m]++;
                    lat[k][m] = cyc - start[k][m];
                    if (last[k] > 0) gap[k] = cyc - last[k];
                    last[k] = cyc;
                    ord[k] = {ord[k][2:0], m[0]};
                end
                v = issued[k][m] > done[k][m];
                if (v && !rv[k][m]) start[k][m] = cyc;
                rv[k][m] = v;
            end
        end
        if (lit_phase != lit_seen) begin
            lit_seen = lit_phase;
            chk("no_timeout", lit_phase, 32'(tmo), 0);
            case (lit_phase)
                1: begin
                    chk("wr_latency", 1, 32'(lat[1][0]), 2);
                    chk("wr_addr", 1, 32'(sa[1]), 32'hDF00);
                    chk("wr_data", 1, 32'(sd[1]), 32'h5A);
                    chk("wr_strobes", 1, 32'(nws[1]), 1);
                    chk("wr_rdata_kept", 1, 32'(rrd[1]), 0);
                end
                2: begin
                    chk("rd_latency", 2, 32'(lat[2][1]), 4);
                    chk("rd_data", 2, 32'(rrd[2][15:8]), 32'h3C);
                    chk("rd_strobes", 2, 32'(nrs[2]), 1);
                end
                3: begin
                    chk("rr_order", 2, 32'(ord[2]), 32'b0101);
                    chk("rr_spacing", 2, 32'(gap[2]), 5);
                    chk("rr_rdata", 2, 32'(rrd[2]), 32'hA3A1);
                end
                4: begin
                    chk("unmapped_data", 2, 32'(rrd[2][7:0]), 32'hFF);
                    chk("unmapped_lat", 2, 32'(lat[2][0]), 4);
                end
                5: begin
                    chk("lat0_latency", 0, 32'(lat[0][1]), 2);
                    chk("lat0_data", 0, 32'(rrd[0][15:8]), 32'h3C);
                    chk("lat0_strobes", 0, 32'(nrs[0]), 1);
                end
                6: begin
                    chk("post_reset_order", 2, 32'(ord[2][1:0]), 32'b01);
                    chk("post_reset_rdata", 2, 32'(rrd[2]), 32'h3CA2);
                end
                default: ;
            endcase
        end
    end

    task automatic req(input int k, input int m, input bit we,
                       input logic [15:0] a, input logic [7:0] d, input int n);
        rwe[k][m] = we;
        raddr[k][m*16 +: 16] = a;
        rwd[k][m*8 +: 8] = d;
        issued[k][m] += n;
    endtask

    task automatic wait_done(input int k, input int m);
        int b = 0;
        while (done[k][m] < issued[k][m] && b < 300) begin
            @(posedge clk);
            b++;
        end
        if (b >= 300) tmo++;
        repeat (3) @(posedge clk);
    endtask

    task automatic lit(input int p);
        lit_phase = p;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            rwe[k] = '0;
            raddr[k] = '0;
            rwd[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(posedge clk); #1;
        req(1, 0, 1'b1, 16'hDF00, 8'h5A, 1);
        wait_done(1, 0);
        lit(1);

        @(posedge clk); #1;
        req(2, 1, 1'b0, 16'hDF02, 8'h00, 1);
        wait_done(2, 1);
        lit(2);

        @(posedge clk); #1;
        req(2, 0, 1'b0, 16'hDF04, 8'h00, 2);
        req(2, 1, 1'b0, 16'hDF06, 8'h00, 2);
        wait_done(2, 0);
        wait_done(2, 1);
        lit(3);

        @(posedge clk); #1;
        req(2, 0, 1'b0, 16'h1234, 8'h00, 1);
        wait_done(2, 0);
        lit(4);

        @(posedge clk); #1;
        req(0, 1, 1'b0, 16'hDF02, 8'h00, 1);
        wait_done(0, 1);
        lit(5);

        @(posedge clk); #1;
        req(2, 0, 1'b0, 16'hDF03, 8'h00, 1);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        issued[2][0] = done[2][0];
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;
        req(2, 0, 1'b0, 16'hDF07, 8'h00, 1);
        req(2, 1, 1'b0, 16'hDF02, 8'h00, 1);
        wait_done(2, 0);
        wait_done(2, 1);
        lit(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
